// File: rtl/ram_dp_clr.sv
// rtl/ram_dp_clr.sv - one-write/two-read node memory with write forwarding and zero-clear sweep
// Reads are synchronous; the array is usable only while ready is high.
`ifndef MEMORY_DATA_WIDTH
`define MEMORY_DATA_WIDTH 64
`endif
`ifndef MEMORY_ADDR_WIDTH
`define MEMORY_ADDR_WIDTH 10
`endif

module ram_dp_clr #(
  parameter int DATA_WIDTH = `MEMORY_DATA_WIDTH,
  parameter int ADDR_WIDTH = `MEMORY_ADDR_WIDTH,
  parameter int DEPTH      = 1024,
  parameter int OUT_REG    = 0
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  init_req,
  output logic                  ready,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd1_en,
  input  logic [ADDR_WIDTH-1:0] rd1_addr,
  output logic [DATA_WIDTH-1:0] rd1_data,
  output logic                  rd1_valid,
  input  logic                  rd2_en,
  input  logic [ADDR_WIDTH-1:0] rd2_addr,
  output logic [DATA_WIDTH-1:0] rd2_data,
  output logic                  rd2_valid
);

  localparam int                    IDX_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_clr_addr;
  logic                  r_ready;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                         w_wr_ok;
  logic [1:0]                   w_rd_en;
  logic [1:0][ADDR_WIDTH-1:0]   w_rd_addr;

  assign w_wr_ok   = r_ready && wr_en && ({1'b0, wr_addr} < DEPTH_W);
  assign w_rd_en   = {rd2_en, rd1_en};
  assign w_rd_addr = {rd2_addr, rd1_addr};
  assign ready     = r_ready;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_CLEAR;
      r_clr_addr <= '0;
      r_ready    <= 1'b0;
    end else begin
      case (r_state)
        S_CLEAR: begin
          if (r_clr_addr == LAST_ADDR) begin
            r_state    <= S_READY;
            r_ready    <= 1'b1;
            r_clr_addr <= '0;
          end else begin
            r_clr_addr <= r_clr_addr + 1'b1;
          end
        end
        S_READY: begin
          if (init_req) begin
            r_state    <= S_CLEAR;
            r_ready    <= 1'b0;
            r_clr_addr <= '0;
          end
        end
        default: begin
          r_state    <= S_CLEAR;
          r_ready    <= 1'b0;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

  // The sweep owns the write port while not ready; user writes are dropped then.
  always_ff @(posedge clock) begin
    if (!r_ready) begin
      r_mem[r_clr_addr[IDX_W-1:0]] <= '0;
    end else if (w_wr_ok) begin
      r_mem[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic                  w_in_range;
    logic                  w_fire;
    logic [DATA_WIDTH-1:0] w_next;
    logic                  w_vout;
    logic [DATA_WIDTH-1:0] w_dout;
    logic                  r_v1;
    logic [DATA_WIDTH-1:0] r_d1;

    assign w_in_range = ({1'b0, w_rd_addr[p]} < DEPTH_W);
    assign w_fire     = r_ready && w_rd_en[p];

    always_comb begin
      w_next = '0;
      if (w_in_range) begin
        w_next = (w_wr_ok && (wr_addr == w_rd_addr[p])) ? wr_data
                                                        : r_mem[w_rd_addr[p][IDX_W-1:0]];
      end
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_v1 <= 1'b0;
        r_d1 <= '0;
      end else begin
        r_v1 <= w_fire;
        if (w_fire) r_d1 <= w_next;
      end
    end

    if (OUT_REG != 0) begin : g_oreg
      logic                  r_v2;
      logic [DATA_WIDTH-1:0] r_d2;

      always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
          r_v2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign w_vout = r_v2;
      assign w_dout = r_d2;
    end else begin : g_noreg
      assign w_vout = r_v1;
      assign w_dout = r_d1;
    end
  end

  assign rd1_valid = g_port[0].w_vout;
  assign rd1_data  = g_port[0].w_dout;
  assign rd2_valid = g_port[1].w_vout;
  assign rd2_data  = g_port[1].w_dout;

endmodule

// File: tb/tb_ram_dp_clr.sv
// tb/tb_ram_dp_clr.sv - randomized model-checked bench for ram_dp_clr, OUT_REG=0 and OUT_REG=1 side by side
module tb_ram_dp_clr;

  localparam int DW = 8;
  localparam int AW = 5;
  localparam int DP = 16;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          init_req, wr_en, rd1_en, rd2_en;
  logic [AW-1:0] wr_addr, rd1_addr, rd2_addr;
  logic [DW-1:0] wr_data;

  logic          ready0, ready1, rd1_valid0, rd2_valid0, rd1_valid1, rd2_valid1;
  logic [DW-1:0] rd1_data0, rd2_data0, rd1_data1, rd2_data1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(0)) dut0 (
    .clock(clock), .reset_n(reset_n), .init_req(init_req), .ready(ready0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data0), .rd1_valid(rd1_valid0),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_data0), .rd2_valid(rd2_valid0)
  );

  ram_dp_clr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP), .OUT_REG(1)) dut1 (
    .clock(clock), .reset_n(reset_n), .init_req(init_req), .ready(ready1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd1_en(rd1_en), .rd1_addr(rd1_addr), .rd1_data(rd1_data1), .rd1_valid(rd1_valid1),
    .rd2_en(rd2_en), .rd2_addr(rd2_addr), .rd2_data(rd2_data1), .rd2_valid(rd2_valid1)
  );

  // Reference model: contents as a plain array, a sweep as "DP cycles busy, then all zero".
  logic [DW-1:0] m_mem [DP];
  int            m_clear_left;
  logic          e0_v [2];
  logic          e1_v [2];
  logic [DW-1:0] e0_d [2];
  logic [DW-1:0] e1_d [2];

  task automatic m_reset();
    m_clear_left = DP;
    for (int i = 0; i < DP; i++) m_mem[i] = '0;
    for (int p = 0; p < 2; p++) begin
      e0_v[p] = 1'b0; e1_v[p] = 1'b0; e0_d[p] = '0; e1_d[p] = '0;
    end
  endtask

  function automatic logic [37:0] dut_word();
    return {ready0, ready1, rd1_valid0, rd2_valid0, rd1_valid1, rd2_valid1,
            rd1_data0, rd2_data0, rd1_data1, rd2_data1};
  endfunction

  function automatic logic [37:0] exp_word();
    return {m_clear_left == 0, m_clear_left == 0, e0_v[0], e0_v[1], e1_v[0], e1_v[1],
            e0_d[0], e0_d[1], e1_d[0], e1_d[1]};
  endfunction

  task automatic idle();
    init_req = 1'b0; wr_en = 1'b0; rd1_en = 1'b0; rd2_en = 1'b0;
    wr_addr = '0; rd1_addr = '0; rd2_addr = '0; wr_data = '0;
  endtask

  // Advance one clock and move the model forward by the same edge.
  task automatic step();
    logic          nv [2];
    logic [DW-1:0] nd [2];
    logic [AW-1:0] a  [2];
    logic          en [2];
    a[0] = rd1_addr; a[1] = rd2_addr; en[0] = rd1_en; en[1] = rd2_en;
    for (int p = 0; p < 2; p++) begin
      nv[p] = 1'b0;
      nd[p] = e0_d[p];
      if (m_clear_left == 0 && en[p]) begin
        nv[p] = 1'b1;
        if (a[p] >= DP) nd[p] = '0;
        else if (wr_en && wr_addr == a[p]) nd[p] = wr_data;
        else nd[p] = m_mem[a[p]];
      end
    end
    @(posedge clock);
    #1;
    for (int p = 0; p < 2; p++) begin
      e1_v[p] = e0_v[p]; e1_d[p] = e0_d[p];
      e0_v[p] = nv[p];   e0_d[p] = nd[p];
    end
    if (m_clear_left > 0) begin
      m_clear_left--;
    end else begin
      if (wr_en && wr_addr < DP) m_mem[wr_addr] = wr_data;
      if (init_req) begin
        m_clear_left = DP;
        for (int i = 0; i < DP; i++) m_mem[i] = '0;
      end
    end
  endtask

  task automatic test_reset();
    int hits;
    idle();
    reset_n = 1'b0;
    m_reset();
    #2;
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL reset_state got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
    repeat (2) @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= DP; i++) begin
      step();
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL reset_sweep cyc=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    hits = 0;
    for (int i = 0; i < DP + 2; i++) begin
      rd1_en = (i < DP); rd1_addr = AW'(i);
      rd2_en = (i < DP); rd2_addr = AW'(DP - 1 - i);
      step();
      if (rd1_valid0 && rd1_data0 == '0) hits++;
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL reset_readback i=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    if (hits !== DP) begin
      n_err++; $display("FAIL reset_zero_pulses got=%0d exp=%0d", hits, DP);
    end
    n_vec++;
    idle();
  endtask

  task automatic test_simultaneous();
    idle();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 8'hA5;
    step();
    wr_addr = 5'd7; wr_data = 8'h11;
    step();
    wr_addr = 5'd3; wr_data = 8'h5A;
    rd1_en = 1'b1; rd1_addr = 5'd3; rd2_en = 1'b1; rd2_addr = 5'd7;
    step();
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL simul_model got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
    if ({rd1_valid0, rd2_valid0, rd1_data0, rd2_data0} !== {1'b1, 1'b1, 8'h5A, 8'h11}) begin
      n_err++;
      $display("FAIL simul_forward got v=%b%b d=%h/%h exp v=11 d=5a/11",
               rd1_valid0, rd2_valid0, rd1_data0, rd2_data0);
    end
    n_vec++;
    idle();
    step();
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL simul_outreg got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
  endtask

  task automatic test_out_reg();
    int hits, first, last;
    hits = 0; first = -1; last = -1;
    idle();
    rd1_en = 1'b1; rd1_addr = 5'd3;
    for (int i = 1; i <= 6; i++) begin
      if (i == 5) idle();
      step();
      if (rd1_valid1 && rd1_data1 == 8'h5A) begin
        hits++;
        if (first < 0) first = i;
        last = i;
      end
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL outreg_model cyc=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    if (hits !== 4 || first !== 2 || last !== 5) begin
      n_err++; $display("FAIL outreg_window got hits=%0d first=%0d last=%0d exp 4/2/5", hits, first, last);
    end
    n_vec++;
  endtask

  task automatic test_sweep();
    int stray;
    stray = 0;
    idle();
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 8'hFF;
    step();
    idle();
    init_req = 1'b1;
    step();
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL sweep_start got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
    for (int i = 1; i <= DP; i++) begin
      init_req = 1'($urandom);
      wr_en = 1'($urandom); wr_addr = 5'd5; wr_data = 8'($urandom);
      rd1_en = 1'b1; rd1_addr = AW'($urandom_range(0, DP - 1));
      rd2_en = 1'($urandom); rd2_addr = 5'd5;
      step();
      stray += rd1_valid0 + rd2_valid0 + rd1_valid1 + rd2_valid1;
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL sweep_busy cyc=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    if (stray !== 0) begin
      n_err++; $display("FAIL sweep_no_valid got=%0d exp=0", stray);
    end
    n_vec++;
    idle();
    rd1_en = 1'b1; rd1_addr = 5'd5; rd2_en = 1'b1; rd2_addr = 5'd5;
    step();
    if ({ready0, rd1_valid0, rd2_valid0, rd1_data0, rd2_data0} !== {3'b111, 8'h00, 8'h00}) begin
      n_err++;
      $display("FAIL sweep_cleared got r=%b v=%b%b d=%h/%h exp r=1 v=11 d=00/00",
               ready0, rd1_valid0, rd2_valid0, rd1_data0, rd2_data0);
    end
    n_vec++;
    idle();
  endtask

  task automatic test_out_of_range();
    idle();
    for (int i = 0; i < DP; i++) begin
      wr_en = 1'b1; wr_addr = AW'(i); wr_data = 8'($urandom);
      step();
    end
    wr_addr = 5'd20; wr_data = 8'h77;
    step();
    idle();
    rd2_en = 1'b1; rd2_addr = 5'd20;
    step();
    if ({rd2_valid0, rd2_data0} !== {1'b1, 8'h00}) begin
      n_err++; $display("FAIL oor_read got v=%b d=%h exp v=1 d=00", rd2_valid0, rd2_data0);
    end
    n_vec++;
    for (int i = 0; i < DP + 2; i++) begin
      idle();
      rd1_en = (i < DP); rd1_addr = AW'(i);
      rd2_en = (i < DP); rd2_addr = AW'(i);
      step();
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL oor_intact i=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    idle();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      init_req = ($urandom_range(0, 63) == 0);
      wr_en    = 1'($urandom);
      wr_addr  = AW'($urandom_range(0, DP + 7));
      wr_data  = 8'($urandom);
      rd1_en   = 1'($urandom);
      rd1_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, DP + 7));
      rd2_en   = 1'($urandom);
      rd2_addr = ($urandom_range(0, 3) == 0) ? rd1_addr : AW'($urandom_range(0, DP + 7));
      step();
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL random i=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    for (int i = 0; i < 2 * DP && m_clear_left > 0; i++) step();
    if (m_clear_left !== 0 || ready0 !== 1'b1) begin
      n_err++; $display("FAIL mid_ready_wait got ready=%b exp 1", ready0);
    end
    n_vec++;
    rd1_en = 1'b1; rd1_addr = AW'($urandom_range(0, DP - 1));
    step();
    reset_n = 1'b0;
    m_reset();
    #1;
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL mid_kill_inflight got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
    idle();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      rd1_en = 1'b1; rd1_addr = AW'(i);
      step();
    end
    reset_n = 1'b0;
    m_reset();
    #1;
    if (dut_word() !== exp_word()) begin
      n_err++; $display("FAIL mid_kill_sweep got=%h exp=%h", dut_word(), exp_word());
    end
    n_vec++;
    idle();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    for (int i = 1; i <= DP + 2; i++) begin
      step();
      if (dut_word() !== exp_word()) begin
        n_err++; $display("FAIL mid_resweep cyc=%0d got=%h exp=%h", i, dut_word(), exp_word());
      end
      n_vec++;
    end
  endtask

  initial begin
    idle();
    m_reset();
    test_reset();
    test_simultaneous();
    test_out_reg();
    test_sweep();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
